// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: PC-select encoding, fetch FSM
// states and the NOP word that the instruction register holds out of reset.
// The PC_SRC_* values must match the control decoder's encoding.
package riscv_pkg;

  // Next-PC select encoding driven by the control decoder (2'b11 acts as PC+4)
  localparam logic [1:0] PC_SRC_JALR   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_PC4    = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/riscv_pc_next.sv
// Next-PC mux and word-alignment check for the fetch stage.
// Purely combinational: zero latency, no handshake and no backpressure.
// The reserved select value falls through to PC+4.
module riscv_pc_next
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  PC_src,
  input  logic        mask,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        next_misaligned
);

  // Select the candidate next PC; JALR optionally drops bit 0 of its target
  always_comb begin
    next_pc = pc + 32'd4;
    case (PC_src)
      PC_SRC_JALR:   next_pc = jalr_target & ~{31'b0, mask};
      PC_SRC_BRANCH: next_pc = branch_target;
      default:       next_pc = pc + 32'd4;
    endcase
  end

  // Fetches are word-sized, so any nonzero low bit is a fault
  assign next_misaligned = |next_pc[1:0];

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch: holds the PC, issues one word fetch per instruction and
// presents the returned word until it retires. 3 cycles/instr at 1-cycle memory.
// Waits indefinitely for imem_rvalid; holds the instruction until advance.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PC_src,
  input  logic        mask,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_target,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned,
  output logic [31:0] instret
);

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         next_misaligned;

  riscv_pc_next u_pc_next (
    .pc              (pc),
    .PC_src          (PC_src),
    .mask            (mask),
    .jalr_target     (jalr_target),
    .branch_target   (branch_target),
    .next_pc         (next_pc),
    .next_misaligned (next_misaligned)
  );

  // Link value for JAL/JALR, always relative to the instruction being held
  assign pc_plus4 = pc + 32'd4;

  // Fetch sequencer; every output is registered so imem_req/imem_addr are
  // already valid in the first cycle of FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      misaligned  <= 1'b0;
      instret     <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: begin
          state     <= ST_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        ST_FETCH: begin
          // request strobe lasts exactly one cycle
          state    <= ST_WAIT;
          imem_req <= 1'b0;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (advance) begin
            // the retiring instruction counts even if its target faults
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            if (next_misaligned) begin
              // pc keeps the faulting instruction's address for diagnosis
              state      <= ST_HALT;
              misaligned <= 1'b1;
            end else begin
              pc        <= next_pc;
              imem_addr <= next_pc;
              imem_req  <= 1'b1;
              state     <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          // terminal until reset
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          misaligned  <= 1'b1;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit. A second instance with RESET_PC at the
// top of the address space shares all inputs and is used for the wrap check.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  PC_src = 2'b10;
  logic        mask = 1'b0;
  logic [31:0] jalr_target = 32'h0;
  logic [31:0] branch_target = 32'h0;
  logic        advance = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, instruction, pc, pc_plus4, instret;
  logic        w_imem_req, w_instr_valid, w_misaligned;
  logic [31:0] w_imem_addr, w_instruction, w_pc, w_pc_plus4, w_instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PC_src(PC_src), .mask(mask),
    .jalr_target(jalr_target), .branch_target(branch_target), .advance(advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned), .instret(instret)
  );

  riscv_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .PC_src(PC_src), .mask(mask),
    .jalr_target(jalr_target), .branch_target(branch_target), .advance(advance),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instruction(w_instruction), .instr_valid(w_instr_valid),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .misaligned(w_misaligned), .instret(w_instret)
  );

  // Pulse reset for one cycle; returns on the falling edge where rst drops
  task automatic do_reset();
    rst = 1'b1;
    advance = 1'b0;
    imem_rvalid = 1'b0;
    PC_src = 2'b10;
    mask = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a fetch request, then answer it after lat cycles.
  // Returns in the first HOLD cycle.
  task automatic serve(input int lat, input logic [31:0] data,
                       output logic [31:0] addr, output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    addr = 32'h0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        addr = imem_addr;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (ok) begin
      repeat (lat) @(negedge clk);
      imem_rvalid = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  // Retire the held instruction, then park the select inputs on a misaligned
  // target so any late sampling would be visible
  task automatic retire(input logic [1:0] src, input logic m,
                        input logic [31:0] jt, input logic [31:0] bt);
    PC_src = src;
    mask = m;
    jalr_target = jt;
    branch_target = bt;
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    PC_src = 2'b01;
    mask = 1'b0;
    jalr_target = 32'h3;
    branch_target = 32'h3;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want %h", pc, 32'h0); end
    checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL rst_instr got %h want %h", instruction, 32'h13); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", misaligned); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL rst_instret got %h want 0", instret); end
    checks++; if (w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_waddr got %h want fffffffc", w_imem_addr); end
    rst = 1'b0;
    // BOOT cycle: no request yet
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b want 0", imem_req); end
    @(negedge clk);
    // FETCH cycle
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 0", imem_addr); end
    @(negedge clk);
    // WAIT cycle: request has dropped, memory answers now
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL req_one_cycle got %b want 0", imem_req); end
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", instr_valid); end
    checks++; if (instruction !== 32'h0050_0093) begin errors++; $display("FAIL first_instr got %h want 00500093", instruction); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h want 0", pc); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL first_pc4 got %h want 4", pc_plus4); end
  endtask

  task automatic test_straight_line();
    logic [31:0] addr;
    int cyc;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      serve(1, 32'h0010_0093 + i, addr, cyc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_timeout[%0d] got none want req", i); end
      checks++; if (addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got %h want %h", i, addr, 32'(4 * i)); end
      // BOOT costs one cycle before the first request; afterwards requests are back to back
      checks++; if (cyc !== (i == 0 ? 1 : 0)) begin errors++; $display("FAIL seq_gap[%0d] got %0d want %0d", i, cyc, (i == 0 ? 1 : 0)); end
      checks++; if (instruction !== 32'h0010_0093 + i) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, instruction, 32'h0010_0093 + i); end
      retire(2'b10, 1'b0, 32'h0, 32'h0);
    end
    checks++; if (instret !== 32'd4) begin errors++; $display("FAIL seq_instret got %0d want 4", instret); end
  endtask

  task automatic test_branch_jalr();
    logic [31:0] addr;
    int cyc;
    bit ok;
    // continues from the straight-line run: next fetch is at 16
    serve(1, 32'h0000_0063, addr, cyc, ok);
    checks++; if (addr !== 32'h10 || !ok) begin errors++; $display("FAIL br_pre_addr got %h want 10", addr); end
    retire(2'b01, 1'b0, 32'h1234_5671, 32'h40);
    serve(1, 32'h0000_0067, addr, cyc, ok);
    checks++; if (addr !== 32'h40 || !ok) begin errors++; $display("FAIL br_addr got %h want 40", addr); end
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_pc got %h want 40", pc); end
    retire(2'b00, 1'b1, 32'h81, 32'h999);
    serve(1, 32'h0000_0013, addr, cyc, ok);
    checks++; if (addr !== 32'h80 || !ok) begin errors++; $display("FAIL jalr_addr got %h want 80", addr); end
    retire(2'b11, 1'b0, 32'h101, 32'h203);
    serve(1, 32'h0000_0013, addr, cyc, ok);
    checks++; if (addr !== 32'h84 || !ok) begin errors++; $display("FAIL rsvd_addr got %h want 84", addr); end
    retire(2'b00, 1'b0, 32'h200, 32'h44);
    serve(1, 32'h0000_0013, addr, cyc, ok);
    checks++; if (addr !== 32'h200 || !ok) begin errors++; $display("FAIL jalr_nomask_addr got %h want 200", addr); end
    checks++; if (instret !== 32'd8) begin errors++; $display("FAIL br_instret got %0d want 8", instret); end
  endtask

  task automatic test_misaligned();
    int reqs;
    // held instruction at 0x200 jumps to a half-word address
    retire(2'b01, 1'b0, 32'h0, 32'h42);
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", misaligned); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_valid got %b want 0", instr_valid); end
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL mis_pc got %h want 200", pc); end
    checks++; if (instret !== 32'd9) begin errors++; $display("FAIL mis_instret got %0d want 9", instret); end
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) reqs++;
      advance = i[0];
      imem_rvalid = i[1];
      PC_src = 2'b10;
      @(negedge clk);
    end
    advance = 1'b0;
    imem_rvalid = 1'b0;
    checks++; if (reqs !== 0) begin errors++; $display("FAIL halt_req got %0d want 0", reqs); end
    checks++; if (misaligned !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky got %b/%b want 1/0", misaligned, instr_valid); end
    checks++; if (instret !== 32'd9 || pc !== 32'h200) begin errors++; $display("FAIL halt_state got %0d/%h want 9/200", instret, pc); end
    do_reset();
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misaligned); end
  endtask

  task automatic test_latency();
    bit ok;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (imem_req) ok = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!ok || imem_addr !== 32'h0) begin errors++; $display("FAIL lat_req got %b/%h want 1/0", ok, imem_addr); end
    // four idle WAIT cycles with a stray advance request
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_wait_valid[%0d] got %b want 0", k, instr_valid); end
      advance = 1'b1;
      PC_src = 2'b01;
      branch_target = 32'h3;
    end
    @(negedge clk);
    advance = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hABCD_0037;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (instruction !== 32'hABCD_0037 || instr_valid !== 1'b1) begin errors++; $display("FAIL lat_data got %h/%b want abcd0037/1", instruction, instr_valid); end
    checks++; if (instret !== 32'd0 || misaligned !== 1'b0) begin errors++; $display("FAIL lat_advance_ignored got %0d/%b want 0/0", instret, misaligned); end
    // a response while holding must not overwrite the instruction
    imem_rvalid = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (instruction !== 32'hABCD_0037) begin errors++; $display("FAIL hold_rvalid got %h want abcd0037", instruction); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    retire(2'b10, 1'b0, 32'h0, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (imem_req) ok = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!ok || imem_addr !== 32'h4) begin errors++; $display("FAIL rw_req got %b/%h want 1/4", ok, imem_addr); end
    @(negedge clk);
    checks++; if (pc !== 32'h4 || instret !== 32'd1) begin errors++; $display("FAIL rw_pre got %h/%0d want 4/1", pc, instret); end
    // asynchronous reset mid-cycle, checked before any clock edge
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || instret !== 32'd0) begin errors++; $display("FAIL rw_pc_instret got %h/%0d want 0/0", pc, instret); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_req_addr got %b/%h want 0/0", imem_req, imem_addr); end
    checks++; if (instruction !== 32'h13 || instr_valid !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL rw_instr got %h/%b/%b want 13/0/0", instruction, instr_valid, misaligned); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] addr;
    int cyc;
    bit ok;
    do_reset();
    serve(1, 32'h0000_0013, addr, cyc, ok);
    checks++; if (!ok || w_pc !== 32'hFFFF_FFFC || w_instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_hold got %h/%b want fffffffc/1", w_pc, w_instr_valid); end
    checks++; if (w_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", w_pc_plus4); end
    retire(2'b10, 1'b0, 32'h0, 32'h0);
    checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %b/%h want 1/0", w_imem_req, w_imem_addr); end
    checks++; if (w_instret !== 32'd1 || w_misaligned !== 1'b0 || w_instruction !== 32'h13) begin errors++; $display("FAIL wrap_misc got %0d/%b/%h want 1/0/13", w_instret, w_misaligned, w_instruction); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_branch_jalr();
    test_misaligned();
    test_latency();
    test_reset_in_wait();
    test_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
